// File: rtl/run_monitor.sv
// run_monitor: retire-stream monitor with IDLE/RUN/HALT control, cycle/instret counters,
// EBREAK/ECALL/watchdog halting and an optional PC trace ring (enabled by RUN_MONITOR_TRACE_EN).
module run_monitor #(
  parameter int XLEN          = 32,
  parameter int CNT_W         = 32,
  parameter int MAX_CYCLES    = 1000,
  parameter int HALT_ON_ECALL = 0,
  parameter int TRACE_DEPTH   = 16,
  localparam int IDX_W        = $clog2(TRACE_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      instruction,
  input  logic             clear,
  input  logic [IDX_W-1:0] trace_idx,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [XLEN-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count,
  output logic [XLEN-1:0]  trace_pc,
  output logic [IDX_W:0]   trace_count
);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_EBRK  = 2'b01;
  localparam logic [1:0] CAUSE_ECALL = 2'b10;
  localparam logic [1:0] CAUSE_TMO   = 2'b11;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MAX_CYCLES > 0 ? MAX_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [1:0]       cause_q, cause_d;
  logic [XLEN-1:0]  hpc_q, hpc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             run_cycle;
  logic             trace_we;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    hpc_d     = hpc_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    run_cycle = 1'b0;
    trace_we  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      cause_d = CAUSE_NONE;
      hpc_d   = '0;
      cyc_d   = '0;
      ret_d   = '0;
    end else begin
      // The instruction that wakes IDLE is handled exactly like a RUN-cycle retire.
      run_cycle = (state_q == S_RUN) || (state_q == S_IDLE && instr_valid);
      if (run_cycle) begin
        state_d = S_RUN;
        cyc_d   = cyc_q + CNT_W'(1);
        if (instr_valid) begin
          ret_d    = ret_q + CNT_W'(1);
          trace_we = 1'b1;
        end
        if (instr_valid && instruction == EBREAK) begin
          state_d = S_HALT;
          cause_d = CAUSE_EBRK;
          hpc_d   = pc;
        end else if (instr_valid && instruction == ECALL && HALT_ON_ECALL != 0) begin
          state_d = S_HALT;
          cause_d = CAUSE_ECALL;
          hpc_d   = pc;
        end else if (MAX_CYCLES > 0 && cyc_q == TO_LAST) begin
          state_d = S_HALT;
          cause_d = CAUSE_TMO;
          hpc_d   = '0;
        end
      end
    end
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      cause_q  <= CAUSE_NONE;
      hpc_q    <= '0;
      cyc_q    <= '0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      cause_q  <= cause_d;
      hpc_q    <= hpc_d;
      cyc_q    <= cyc_d;
      ret_q    <= ret_d;
    end
  end

  assign halted        = halted_q;
  assign halt_cause    = cause_q;
  assign halt_pc       = hpc_q;
  assign cycle_count   = cyc_q;
  assign instret_count = ret_q;

`ifdef RUN_MONITOR_TRACE_EN
  logic [XLEN-1:0]  trace_mem [TRACE_DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   tcnt_q, tcnt_d;
  logic [IDX_W-1:0] rd_ptr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    tcnt_d   = tcnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      tcnt_d   = '0;
    end else if (trace_we) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (tcnt_q != (IDX_W+1)'(TRACE_DEPTH)) tcnt_d = tcnt_q + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      tcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Storage has no reset; entries beyond trace_count are never meaningful.
  always_ff @(posedge clk) begin
    if (trace_we) trace_mem[wr_ptr_q] <= pc;
  end

  assign rd_ptr      = wr_ptr_q - trace_idx - IDX_W'(1);
  assign trace_pc    = trace_mem[rd_ptr];
  assign trace_count = tcnt_q;
`else
  logic unused_trace;
  assign unused_trace = ^{trace_idx, trace_we};
  assign trace_pc     = '0;
  assign trace_count  = '0;
`endif

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the PC and data width.
REQ-002 SHALL have parameter CNT_W, default 32, giving the cycle and instret counter width.
REQ-003 SHALL have parameter MAX_CYCLES, default 1000, setting the watchdog limit in RUN-state cycles; 0 disables the watchdog.
REQ-004 SHALL have parameter HALT_ON_ECALL, default 0; when 1, ECALL also halts.
REQ-005 SHALL have parameter TRACE_DEPTH, default 16, a power of two and at least 2, giving the trace buffer entry count.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port instr_valid, input, 1 bit: instruction retires this cycle.
REQ-009 SHALL have port pc, input, XLEN bits: PC of the retiring instruction.
REQ-010 SHALL have port instruction, input, 32 bits: the retiring instruction word.
REQ-011 SHALL have port clear, input, 1 bit: synchronous return to IDLE.
REQ-012 SHALL have port trace_idx, input, log2(TRACE_DEPTH) bits: trace read index, where 0 is the newest entry.
REQ-013 SHALL have port halted, output, 1 bit: sticky halt flag.
REQ-014 SHALL have port halt_cause, output, 2 bits: 00 none, 01 EBREAK, 10 ECALL, 11 timeout.
REQ-015 SHALL have port halt_pc, output, XLEN bits: PC of the halting instruction; 0 on timeout.
REQ-016 SHALL have port cycle_count, output, CNT_W bits: cycles spent in RUN.
REQ-017 SHALL have port instret_count, output, CNT_W bits: retired instructions.
REQ-018 SHALL have port trace_pc, output, XLEN bits: PC at trace_idx, read combinationally.
REQ-019 SHALL have port trace_count, output, log2(TRACE_DEPTH)+1 bits: number of valid trace entries.

Function
REQ-020 SHALL implement states IDLE, RUN, HALT; IDLE moves to RUN on the first cycle with instr_valid=1, and that instruction is processed as in RUN.
REQ-021 In RUN, SHALL increment cycle_count every cycle, and increment instret_count on each cycle with instr_valid=1.
REQ-022 SHALL move RUN to HALT, with cause 01, on instr_valid=1 and instruction==32'h00100073.
REQ-023 SHALL, when HALT_ON_ECALL=1, move RUN to HALT with cause 10 on instr_valid=1 and instruction==32'h00000073; when HALT_ON_ECALL=0, ECALL is counted only.
REQ-024 SHALL count the halting instruction in instret_count, record it in the trace, and capture its PC in halt_pc.
REQ-025 SHALL, when MAX_CYCLES>0 and cycle_count reaches MAX_CYCLES-1 without a halting instruction, move to HALT with cause 11 on the next edge.
REQ-026 SHALL give EBREAK/ECALL priority over timeout in the same cycle.
REQ-027 SHALL assert halted on the cycle after the halting event; halted stays asserted in HALT.
REQ-028 SHALL ignore instr_valid in HALT; all counters, halt_pc, halt_cause and the trace stay frozen.
REQ-029 SHALL make clear take priority over every transition: return to IDLE, zero all counters, halt_cause, halt_pc and trace_count; trace storage contents are undefined afterwards.
REQ-030 SHALL make counters wrap modulo 2^CNT_W with no flag.

Reset
REQ-031 SHALL, on reset low, asynchronously force state IDLE and set halted=0, halt_cause=00, halt_pc=0, cycle_count=0, instret_count=0 and trace_count=0.
REQ-032 SHALL, on reset asserted mid-RUN or in HALT, abandon the state immediately, with outputs reaching reset values without waiting for a clock edge.

Configuration
REQ-033 SHALL, with macro RUN_MONITOR_TRACE_EN defined, write each retired PC into a circular buffer at the write pointer.
REQ-034 SHALL, with RUN_MONITOR_TRACE_EN defined, advance the write pointer with wrap, saturate trace_count at TRACE_DEPTH, and have trace_idx k return the k-th newest entry.
REQ-035 SHALL, with RUN_MONITOR_TRACE_EN undefined, omit the buffer, tie trace_pc and trace_count to 0, and leave all other behaviour identical.

Verification
REQ-036 Reset, then retire 3 NOPs at PC 0,4,8, then 32'h00100073 at PC 12 -> halted=1 the next cycle, halt_cause=01, halt_pc=12, instret_count=4.
REQ-037 HALT_ON_ECALL=0, ECALL at PC 4, then EBREAK at PC 8 -> no halt at the ECALL; halt_cause=01, halt_pc=8.
REQ-038 HALT_ON_ECALL=1, ECALL at PC 4 -> halt_cause=10, halt_pc=4; further instr_valid pulses leave instret_count unchanged.
REQ-039 MAX_CYCLES=10, no EBREAK -> halted=1 with cause 11 and cycle_count=10; EBREAK on the final RUN cycle -> cause 01.
REQ-040 With RUN_MONITOR_TRACE_EN defined and TRACE_DEPTH=4, retire 6 PCs 0..20 -> trace_count=4; trace_idx 0..3 gives 20,16,12,8.
REQ-041 Assert reset low mid-RUN between edges -> halted, all counters and trace_count read 0 before the next edge; the next instr_valid restarts RUN.
